// File: rtl/sys_mem.sv
// sys_mem: word RAM with byte-lane writes plus four MMIO words (TX FIFO, STATUS, CYCLE, GPIO).
// Optional SYS_MEM_BUS_ERR_EN adds a sticky bus_err output for unmapped accesses.
module sys_mem #(
    parameter int M_WIDTH    = 8,
    parameter int A_WIDTH    = M_WIDTH - $clog2(M_WIDTH / 8),
    parameter int RAM_DEPTH  = 2 ** A_WIDTH - 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   addr,
    input  logic [M_WIDTH-1:0]   data_out,
    input  logic [M_WIDTH/8-1:0] wes,
    output logic [M_WIDTH-1:0]   data_in,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [M_WIDTH-1:0]   gpio_out
`ifdef SYS_MEM_BUS_ERR_EN
    ,
    output logic                 bus_err
`endif
);

    localparam int NB = M_WIDTH / 8;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    localparam logic [A_WIDTH-1:0] A_GPIO = '1;
    localparam logic [A_WIDTH-1:0] A_CYC  = A_GPIO - A_WIDTH'(1);
    localparam logic [A_WIDTH-1:0] A_STAT = A_GPIO - A_WIDTH'(2);
    localparam logic [A_WIDTH-1:0] A_TX   = A_GPIO - A_WIDTH'(3);
    localparam logic [A_WIDTH:0]   RAM_END = (A_WIDTH + 1)'(RAM_DEPTH);
    localparam logic [PW:0]        CNT_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [M_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RW-1:0]      ram_idx;

    logic               we;
    logic               is_ram;
    logic               hit_tx;
    logic               hit_st;
    logic               hit_cyc;
    logic               hit_gpio;

    logic [7:0]         fifo [FIFO_DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [PW:0]        cnt;
    logic               full;
    logic               empty;
    logic               pop;
    logic               push_req;
    logic               push_ok;
    logic               ovf_set;
    logic               ovf;

    logic [M_WIDTH-1:0] cycle;
    logic               berr;
    logic [3:0]         status;
    logic [M_WIDTH-1:0] rd_val;

    assign we       = |wes;
    assign ram_idx  = addr[RW-1:0];
    assign is_ram   = {1'b0, addr} < RAM_END;
    assign hit_tx   = addr == A_TX;
    assign hit_st   = addr == A_STAT;
    assign hit_cyc  = addr == A_CYC;
    assign hit_gpio = addr == A_GPIO;

    assign full     = cnt == CNT_FULL;
    assign empty    = cnt == '0;
    assign tx_valid = !empty;
    assign tx_data  = fifo[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = we && hit_tx;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_ok  = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    assign status   = {berr, ovf, empty, full};

`ifdef SYS_MEM_BUS_ERR_EN
    logic unmapped;

    assign unmapped = !is_ram && (addr < A_TX);
    assign berr     = bus_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (unmapped) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign berr = 1'b0;
`endif

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            is_ram:   rd_val = ram[ram_idx];
            hit_st:   rd_val = M_WIDTH'(status);
            hit_cyc:  rd_val = cycle;
            hit_gpio: rd_val = gpio_out;
            default:  rd_val = '0;
        endcase
    end

    // RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we && is_ram) begin
            for (int i = 0; i < NB; i++) begin
                if (wes[i]) begin
                    ram[ram_idx][8*i +: 8] <= data_out[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_in <= '0;
        end else begin
            data_in <= rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle <= '0;
        end else if (we && hit_cyc) begin
            cycle <= '0;
        end else begin
            cycle <= cycle + M_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpio_out <= '0;
        end else if (hit_gpio) begin
            for (int i = 0; i < NB; i++) begin
                if (wes[i]) begin
                    gpio_out[8*i +: 8] <= data_out[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (we && hit_st) begin
            ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo[wr_ptr] <= data_out[7:0];
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push_ok && !pop) begin
                cnt <= cnt + (PW + 1)'(1);
            end else if (pop && !push_ok) begin
                cnt <= cnt - (PW + 1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_sys_mem.sv
// Scoreboard bench for sys_mem at M_WIDTH=16 with a 16-word RAM.
// Reads and TX pops are checked by a monitor against queued expectations.
module tb_sys_mem;

    localparam int MW = 16;
    localparam int AW = 15;
    localparam int RD = 16;

    localparam logic [AW-1:0] A_TX   = 15'h7FFC;
    localparam logic [AW-1:0] A_STAT = 15'h7FFD;
    localparam logic [AW-1:0] A_CYC  = 15'h7FFE;
    localparam logic [AW-1:0] A_GPIO = 15'h7FFF;

`ifdef SYS_MEM_BUS_ERR_EN
    localparam logic [15:0] BE = 16'h0008;
    logic bus_err;
`else
    localparam logic [15:0] BE = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [MW-1:0] data_out = '0;
    logic [1:0]    wes = '0;
    logic [MW-1:0] data_in;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [MW-1:0] gpio_out;
    logic          rd_strobe = 1'b0;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t rdq[$];
    exp_t txq[$];
    int   checks = 0;
    int   errors = 0;

    sys_mem #(
        .M_WIDTH(MW),
        .RAM_DEPTH(RD),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .addr(addr),
        .data_out(data_out),
        .wes(wes),
        .data_in(data_in),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .gpio_out(gpio_out)
`ifdef SYS_MEM_BUS_ERR_EN
        ,
        .bus_err(bus_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string n, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", n, got, exp);
        end
    endtask

    task automatic bus(input logic [AW-1:0] a, input logic [15:0] d,
                       input logic [1:0] w, input logic rdy,
                       input logic rd, input logic [15:0] e,
                       input string n);
        exp_t x;
        @(posedge clk);
        #1;
        addr      = a;
        data_out  = d;
        wes       = w;
        tx_ready  = rdy;
        rd_strobe = rd;
        if (rd) begin
            x.name = n;
            x.val  = e;
            rdq.push_back(x);
        end
    endtask

    task automatic wr_t(input logic [AW-1:0] a, input logic [15:0] d,
                        input logic [1:0] w, input logic rdy);
        bus(a, d, w, rdy, 1'b0, 16'h0, "");
    endtask

    task automatic rd_t(input logic [AW-1:0] a, input logic [15:0] e,
                        input logic rdy, input string n);
        bus(a, 16'h0, 2'b00, rdy, 1'b1, e, n);
    endtask

    task automatic tx_exp(input logic [7:0] b, input string n);
        exp_t x;
        x.name = n;
        x.val  = {8'h00, b};
        txq.push_back(x);
    endtask

    initial begin : mon
        bit   pend;
        exp_t x;
        pend = 1'b0;
        forever begin
            @(negedge clk);
            if (pend) begin
                if (rdq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_queue got read exp none");
                end else begin
                    x = rdq.pop_front();
                    check(x.name, data_in, x.val);
                end
            end
            pend = rd_strobe;
            if (rst && tx_valid && tx_ready) begin
                if (txq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_pop got %h exp none", tx_data);
                end else begin
                    x = txq.pop_front();
                    check(x.name, {8'h00, tx_data}, x.val);
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_data_in", data_in, 16'h0);
        check("rst_tx_valid", {15'h0, tx_valid}, 16'h0);
        check("rst_tx_data", {8'h0, tx_data}, 16'h0);
        check("rst_gpio", gpio_out, 16'h0);
        #2 rst = 1'b1;
        rd_t(A_CYC, 16'h0001, 1'b0, "cyc_after_rst");
        rd_t(A_STAT, 16'h0002, 1'b0, "stat_after_rst");

        // RAM byte lanes
        wr_t(15'd5, 16'hBEEF, 2'b11, 1'b0);
        wr_t(15'd5, 16'h12AB, 2'b10, 1'b0);
        rd_t(15'd5, 16'h12EF, 1'b0, "ram_lane_hi");
        wr_t(15'd5, 16'hFF34, 2'b01, 1'b0);
        rd_t(15'd5, 16'h1234, 1'b0, "ram_lane_lo");
        wr_t(15'd15, 16'h5A5A, 2'b11, 1'b0);
        rd_t(15'd15, 16'h5A5A, 1'b0, "ram_last_word");

        // read-first
        wr_t(15'd3, 16'h0011, 2'b11, 1'b0);
        bus(15'd3, 16'h0022, 2'b11, 1'b0, 1'b1, 16'h0011, "rdw_old");
        rd_t(15'd3, 16'h0022, 1'b0, "rdw_new");

        // GPIO lanes
        wr_t(A_GPIO, 16'hA5A5, 2'b01, 1'b0);
        bus(A_GPIO, 16'h3C00, 2'b10, 1'b0, 1'b1, 16'h00A5, "gpio_rdw");
        rd_t(A_GPIO, 16'h3CA5, 1'b0, "gpio_read");
        check("gpio_out", gpio_out, 16'h3CA5);

        // FIFO fill and overflow
        wr_t(A_TX, 16'h00A1, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00A2, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00A3, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00A4, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00A5, 2'b01, 1'b0);
        rd_t(A_STAT, 16'h0005, 1'b0, "stat_full_ovf");
        tx_exp(8'hA1, "tx_a1");
        tx_exp(8'hA2, "tx_a2");
        tx_exp(8'hA3, "tx_a3");
        tx_exp(8'hA4, "tx_a4");
        repeat (4) wr_t(15'd0, 16'h0, 2'b00, 1'b1);
        rd_t(A_STAT, 16'h0006, 1'b1, "stat_empty_ovf");
        #3 check("tx_valid_drained", {15'h0, tx_valid}, 16'h0);
        wr_t(A_STAT, 16'h0000, 2'b10, 1'b1);
        rd_t(A_STAT, 16'h0002, 1'b0, "stat_ovf_clr");

        // full FIFO with simultaneous push and pop
        wr_t(A_TX, 16'h00C1, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00C2, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00C3, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00C4, 2'b01, 1'b0);
        tx_exp(8'hC1, "tx_c1");
        wr_t(A_TX, 16'h00B0, 2'b01, 1'b1);
        rd_t(A_STAT, 16'h0001, 1'b0, "stat_full_no_ovf");
        tx_exp(8'hC2, "tx_c2");
        tx_exp(8'hC3, "tx_c3");
        tx_exp(8'hC4, "tx_c4");
        tx_exp(8'hB0, "tx_b0_last");
        repeat (4) wr_t(15'd0, 16'h0, 2'b00, 1'b1);
        rd_t(A_STAT, 16'h0002, 1'b1, "stat_after_b0");

        // cycle counter: cleared by the write, read sampled 10 edges later
        wr_t(A_CYC, 16'hFFFF, 2'b10, 1'b0);
        repeat (9) wr_t(A_CYC, 16'h0, 2'b00, 1'b0);
        rd_t(A_CYC, 16'h0009, 1'b0, "cyc_10");
        for (int i = 0; i < 65535; i++) begin
            wr_t(A_CYC, 16'h0, 2'b00, 1'b0);
        end
        rd_t(A_CYC, 16'h0009, 1'b0, "cyc_wrap");

        // unmapped and write-only locations
        wr_t(15'h0100, 16'hFFFF, 2'b11, 1'b0);
        rd_t(15'h0100, 16'h0000, 1'b0, "unmapped_mid");
        rd_t(15'h7FFB, 16'h0000, 1'b0, "unmapped_top");
        rd_t(15'd16, 16'h0000, 1'b0, "unmapped_ram_end");
        rd_t(A_TX, 16'h0000, 1'b0, "txdata_read");
        rd_t(A_STAT, 16'h0002 | BE, 1'b0, "stat_unmapped");

        // async reset mid-drain
        wr_t(A_TX, 16'h00D1, 2'b01, 1'b0);
        wr_t(A_TX, 16'h00D2, 2'b01, 1'b0);
        wr_t(A_GPIO, 16'hFFFF, 2'b11, 1'b0);
        tx_exp(8'hD1, "tx_d1");
        wr_t(15'd0, 16'h0, 2'b00, 1'b1);
        @(posedge clk);
        #2;
        check("pre_rst_valid", {15'h0, tx_valid}, 16'h0001);
        rst = 1'b0;
        #1;
        check("async_tx_valid", {15'h0, tx_valid}, 16'h0);
        check("async_gpio", gpio_out, 16'h0);
        check("async_tx_data", {8'h0, tx_data}, 16'h0);
        check("async_data_in", data_in, 16'h0);
        tx_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        rd_t(A_CYC, 16'h0001, 1'b0, "cyc_post_rst");
        rd_t(A_STAT, 16'h0002, 1'b0, "stat_post_rst");
        rd_t(15'd5, 16'h1234, 1'b0, "ram_kept");
        repeat (3) wr_t(15'd0, 16'h0, 2'b00, 1'b0);
        check("rd_queue_left", 16'(rdq.size()), 16'h0);
        check("tx_queue_left", 16'(txq.size()), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_mem.md
Name: sys_mem

Overview:
- Memory-side target on the core's single memory port (addr / data_out / wes in, data_in out), instantiated next to the core in the SoC top.
- Provides word-addressed RAM with per-byte-lane writes and one-cycle registered reads.
- The top 4 words of the address space are MMIO: a debug TX FIFO with valid/ready drain, a status register, a cycle counter and a GPIO output register.

Parameters:
- M_WIDTH, 8, data word width in bits (multiple of 8).
- A_WIDTH, M_WIDTH-$clog2(M_WIDTH/8), word address width, matching the core's addr port.
- RAM_DEPTH, 2**A_WIDTH-4, number of RAM words at addresses 0..RAM_DEPTH-1 (must be ≤ 2**A_WIDTH-4).
- FIFO_DEPTH, 4, TX FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- addr  input  A_WIDTH  word address from the core.
- data_out  input  M_WIDTH  write data from the core.
- wes  input  M_WIDTH/8  byte-lane write enables; bit i writes data_out[8i+7:8i].
- data_in  output  M_WIDTH  read data to the core.
- tx_data  output  8  FIFO head byte.
- tx_valid  output  1  FIFO non-empty.
- tx_ready  input  1  consumer accepts the head byte this cycle.
- gpio_out  output  M_WIDTH  GPIO register.

Behaviour:
Reset (rst=0, asynchronous assert, synchronous release):
- data_in=0, tx_valid=0, tx_data=0, gpio_out=0.
- FIFO empty, overflow flag 0, cycle counter 0.
- RAM contents are not reset.
- Reset mid-drain drops all queued bytes.

Address map (T = 2**A_WIDTH):
- 0..RAM_DEPTH-1: RAM.
- T-4: TXDATA. Write pushes data_out[7:0]. Reads return 0.
- T-3: STATUS = {0.., overflow, empty, full} at bits [2:0]. Any write clears overflow.
- T-2: CYCLE. Read returns the counter. Any write clears it to 0 (the write takes priority over the increment).
- T-1: GPIO. Byte-lane writes per wes; read returns gpio_out.
- RAM_DEPTH..T-5 (unmapped): writes ignored, reads return 0.

Reads:
- addr is sampled every rising edge. data_in shows that word's value from the cycle after, i.e. 1-cycle latency; there is no read strobe.
- Read-during-write to the same address returns the old value (read-first). This holds for RAM and MMIO.
- MMIO values are zero-extended to M_WIDTH.

Writes:
- A write occurs when any wes bit is set.
- RAM: only the enabled lanes are updated.
- Single-byte MMIO registers (TXDATA, STATUS, CYCLE) act on any nonzero wes and use lane 0.

Cycle counter:
- M_WIDTH bits, increments every cycle out of reset, wraps from 2**M_WIDTH-1 to 0.

TX FIFO:
- Circular buffer with read/write pointers and an occupancy count of $clog2(FIFO_DEPTH)+1 bits.
- tx_data is the head entry, driven combinationally from the storage; tx_valid = !empty.
- Pop occurs when tx_valid && tx_ready at the edge.
- Push while not full: stored; available at the head no earlier than the next cycle.
- Push while full with no pop in the same cycle: byte dropped, overflow set (sticky).
- Push and pop in the same cycle: both succeed and the count is unchanged, including when full. When empty, pop is not possible, so the push succeeds.
- An overflow set and a STATUS write in the same cycle: the set wins.
- Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
SYS_MEM_BUS_ERR_EN
- Defined: adds output bus_err (1 bit, reset 0). It is set sticky on any read or write to an unmapped address, and cleared only by reset. STATUS bit 3 mirrors bus_err.
- Undefined: no bus_err port, STATUS bit 3 reads 0, and unmapped accesses are silent.

Test Plan:
- RAM lanes, M_WIDTH=16: write 0xBEEF with wes=2'b11 to word 5, then write 0x12xx with wes=2'b10 → read of word 5 returns 0x12EF one cycle after addr is presented.
- Read-first: read and write word 3 in the same cycle (old 0x11, new 0x22) → data_in=0x11 on the next cycle; the following read gives 0x22.
- FIFO fill and overflow, FIFO_DEPTH=4, tx_ready=0: push 0xA1..0xA5 → STATUS=0b101 (full, overflow). Raise tx_ready → tx_data yields A1,A2,A3,A4 on consecutive cycles, then tx_valid=0 and STATUS=0b110. Write STATUS → 0b010.
- Full push+pop: with the FIFO full, push 0xB0 while tx_ready=1 → count stays 4, overflow stays 0, and 0xB0 drains last.
- Counter: write CYCLE, read it 10 cycles later → value 0x09 or 0x0A per the documented sample point (pinned by the bench). Let it run 2**M_WIDTH cycles → the value wraps to the same reading.
- Async reset mid-drain: assert rst low between edges → tx_valid and gpio_out drop to 0 immediately, before the next edge. After release, STATUS=0b010.
